fmul_ctl: RTL

Issue/result controller wrapped around the pipelined single-precision multiplier `fmul` (NSTAGE=2). It accepts tagged operand pairs over a valid/ready handshake and drives them into `fmul`. It tracks validity, tag and overflow through the multiplier's fixed latency, and buffers results in an in-order FIFO. Credit-based issue means the unstallable multiplier can never overrun the FIFO. It sits between the FPU dispatch stage and writeback.

---
 rtl/fmul_ctl_pkg.sv | 19 +
 rtl/fmul.sv | 91 +++++++++
 rtl/fpu_res_fifo.sv | 61 ++++++
 rtl/fmul_ctl.sv | 110 +++++++++++
 4 files changed

// File: rtl/fmul_ctl_pkg.sv
// Shared FPU definitions: multiplier latency and the result-buffer entry layout.
package fmul_ctl_pkg;

  // Edges from operand sample to product valid in fmul (NSTAGE=2).
  localparam int FMUL_LAT = 2;

  // Tag width carried in a result entry; controllers use this as their TAGW.
  localparam int FPU_TAGW = 5;

  // One buffered result: product, overflow flag and request tag.
  typedef struct packed {
    logic [31:0]         y;
    logic                ovf;
    logic [FPU_TAGW-1:0] tag;
  } fpu_res_t;

  localparam int FPU_RES_W = $bits(fpu_res_t);

endpackage

// File: rtl/fmul.sv
// Two-stage single-precision multiplier. Stage 1 registers sign, exponent sum and
// the top of the mantissa product; stage 2 registers the packed result.
// Denormal inputs flush to zero, underflow flushes to signed zero, overflow gives
// signed infinity. The dropped product bits are truncated and the result LSB is
// jammed to 1 (truncation bias), so 2.0 * 3.0 = 0x40C00001.
// ovf is combinational from stage 1, i.e. one cycle ahead of y.
module fmul
  import fmul_ctl_pkg::*;
#(
  parameter int NSTAGE = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  output logic        ovf
);

  logic [47:0]       prod_c;
  logic              unused_lo;
  logic              s1_sign;
  logic              s1_zero;
  logic [9:0]        s1_esum;
  logic [24:0]       s1_prod;
  logic              norm_c;
  logic signed [9:0] exp_c;
  logic [22:0]       frac_c;
  logic              uflow_c;
  logic              ovf_c;
  logic [31:0]       y_c;
  logic [31:0]       y_r;

  assign prod_c    = 48'({1'b1, x1[22:0]}) * 48'({1'b1, x2[22:0]});
  // Bits below the kept window are truncated away.
  assign unused_lo = ^prod_c[22:0];

  // Stage 1: capture sign, zero detect, biased exponent sum and product top bits.
  // NOTE: state registers use <= so every flop samples pre-edge values; blocking
  // assignments here would chain stages together within one edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_sign <= 1'b0;
      s1_zero <= 1'b0;
      s1_esum <= '0;
      s1_prod <= '0;
    end else begin
      s1_sign <= x1[31] ^ x2[31];
      s1_zero <= (x1[30:23] == 8'd0) | (x2[30:23] == 8'd0);
      s1_esum <= {2'b00, x1[30:23]} + {2'b00, x2[30:23]};
      s1_prod <= prod_c[47:23];
    end
  end

  // Normalise, classify and pack the stage-1 product.
  // NOTE: every variable gets a value on every path (defaults first) so no latch
  // is inferred.
  always_comb begin
    norm_c  = s1_prod[24];
    exp_c   = $signed(s1_esum) - 10'sd127 + $signed({9'd0, norm_c});
    frac_c  = norm_c ? s1_prod[23:1] : s1_prod[22:0];
    ovf_c   = !s1_zero && (exp_c >= 10'sd255);
    uflow_c = exp_c <= 10'sd0;
    y_c     = {s1_sign, exp_c[7:0], frac_c | 23'd1};
    if (s1_zero || uflow_c) begin
      y_c = {s1_sign, 31'd0};
    end else if (ovf_c) begin
      y_c = {s1_sign, 8'hFF, 23'd0};
    end
  end

  // Stage 2: register the packed product.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      y_r <= '0;
    end else begin
      y_r <= y_c;
    end
  end

  // The controller's shadow pipeline is built for exactly this depth.
  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (NSTAGE == FMUL_LAT);
    end
  end

  assign y   = y_r;
  assign ovf = ovf_c;

endmodule

// File: rtl/fpu_res_fifo.sv
// In-order result FIFO shared by the FPU controllers. DEPTH must be a power of
// two, so pointers wrap by dropping their carry; count runs 0..DEPTH.
module fpu_res_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 38
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_rd;

  assign do_rd   = rd_en && (count != '0);
  assign rd_data = mem[rd_ptr];

  // Pointer, occupancy and storage update.
  // NOTE: the storage is cleared on reset as well, because the head entry drives
  // the result outputs directly and they must read zero after reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Credit-based issue upstream must make a write into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (rstn && wr_en) begin
      assert (count != FULL);
    end
  end

endmodule

// File: rtl/fmul_ctl.sv
// Issue/result controller around fmul: valid/ready request intake, a shadow
// pipeline tracking valid/tag/overflow alongside the multiplier, an in-order
// result FIFO, and credit-based issue so the unstallable multiplier never
// overruns the FIFO.
module fmul_ctl
  import fmul_ctl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAGW  = FPU_TAGW
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_x1,
  input  logic [31:0]     req_x2,
  input  logic [TAGW-1:0] req_tag,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [31:0]     res_y,
  output logic            res_ovf,
  output logic [TAGW-1:0] res_tag,
  output logic [15:0]     ovf_cnt,
  output logic            busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic            v0;
  logic            v1;
  logic            o1;
  logic [TAGW-1:0] t0;
  logic [TAGW-1:0] t1;
  logic [CW-1:0]   count;
  logic [CW:0]     inflight;
  logic            accept;
  logic            fifo_wr;
  logic            fifo_rd;
  logic [31:0]     fmul_y;
  logic            fmul_ovf;
  fpu_res_t        wr_ent;
  fpu_res_t        head;

  // Credits: buffered results plus those still inside the multiplier.
  assign inflight  = {1'b0, count} + {{CW{1'b0}}, v0} + {{CW{1'b0}}, v1};
  assign req_ready = inflight < (CW+1)'(DEPTH);
  assign accept    = req_valid & req_ready;

  assign res_valid = count != '0;
  assign fifo_rd   = res_valid & res_ready;
  assign fifo_wr   = v1;
  assign wr_ent    = '{y: fmul_y, ovf: o1, tag: FPU_TAGW'(t1)};

  assign res_y   = head.y;
  assign res_ovf = head.ovf;
  assign res_tag = TAGW'(head.tag);
  assign busy    = v0 | v1 | (count != '0);

  fmul #(
    .NSTAGE(FMUL_LAT)
  ) u_fmul (
    .clk (clk),
    .rstn(rstn),
    .x1  (req_x1),
    .x2  (req_x2),
    .y   (fmul_y),
    .ovf (fmul_ovf)
  );

  fpu_res_fifo #(
    .DEPTH(DEPTH),
    .W    (FPU_RES_W)
  ) u_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .wr_en  (fifo_wr),
    .wr_data(wr_ent),
    .rd_en  (fifo_rd),
    .rd_data(head),
    .count  (count)
  );

  // Shadow pipeline: valid and tag follow the operands; o1 delays fmul's early
  // overflow flag by one cycle so it lines up with y at the FIFO write.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      t0 <= '0;
      t1 <= '0;
      o1 <= 1'b0;
    end else begin
      v0 <= accept;
      t0 <= req_tag;
      v1 <= v0;
      t1 <= t0;
      o1 <= fmul_ovf;
    end
  end

  // Saturating count of overflowed results written into the FIFO.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf_cnt <= '0;
    end else if (fifo_wr && o1 && (ovf_cnt != 16'hFFFF)) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

endmodule
